// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin arbiter sequencing loads of one shared register from four requesters
module rr_reg_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [3:0]        grant,
  output logic [1:0]        owner,
  output logic              valid,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] q_bar
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] MAX_H = 4'(MAX_HOLD);
  state_t state, state_n;
  logic [1:0] ptr, pick, idx;
  logic [3:0] hold_cnt, hold_n;
  logic stay;
  logic [DATA_W-1:0] d_sel;
  // scan downward so the lowest offset from ptr wins
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
  end
  always_comb begin
    state_n = |req ? BUSY : IDLE;
    stay = (state == BUSY) && req[owner] && (hold_cnt < MAX_H);
    idx = stay ? owner : pick;
    hold_n = stay ? hold_cnt + 4'd1 : 4'd1;
    d_sel = idx == 2'd0 ? d0 : idx == 2'd1 ? d1 : idx == 2'd2 ? d2 : d3;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      valid <= 1'b0;
      q <= '0;
      hold_cnt <= '0;
      ptr <= '0;
    end else begin
      state <= state_n;
      valid <= |req;
      grant <= |req ? 4'b0001 << idx : 4'b0000;
      if (|req) begin
        owner <= idx;
        ptr <= idx + 2'd1;
        q <= d_sel;
        hold_cnt <= hold_n;
      end
    end
  end
  assign q_bar = ~q;
endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
Round-robin arbiter and write sequencer for one shared DATA_W-bit storage register built from the team's D-storage elements. Four requesters compete to load the register. The block grants one requester at a time and sequences the register load from that requester's data. It enforces a bounded hold time so that no requester can starve the others. It sits between requester logic and the shared register, and exposes the register contents as q/q_bar.

Parameters:
DATA_W, 8, width of each requester data bus and of the shared register
MAX_HOLD, 4, maximum consecutive cycles one requester may own the register while others wait (legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  4  request lines; bit i = requester i
d0  input  DATA_W  data from requester 0
d1  input  DATA_W  data from requester 1
d2  input  DATA_W  data from requester 2
d3  input  DATA_W  data from requester 3
grant  output  4  one-hot registered grant; all zero when idle
owner  output  2  index of current/last granted requester
valid  output  1  high for each cycle in which q was loaded on the preceding edge
q  output  DATA_W  shared register contents
q_bar  output  DATA_W  bitwise inverse of q, always

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, grant=4'b0000, owner=0, q=0, q_bar=all ones, valid=0, hold_cnt=0, ptr=0. Requester 0 has top priority after reset.
- Arbitration pick:
  - Search req starting at index ptr, then increasing mod 4.
  - Select the first set bit.
  - ptr is always (owner+1) mod 4 after any grant.
- State IDLE, at clock edge:
  - req==0: remain IDLE; grant=0, valid=0, q holds.
  - req!=0: pick idx, then grant<=onehot(idx), owner<=idx, q<=d[idx], valid<=1, hold_cnt<=1, go BUSY.
- State BUSY, at clock edge, with owner=o:
  - req[o]=1 and hold_cnt<MAX_HOLD: keep grant, q<=d[o], valid<=1, hold_cnt++.
  - req[o]=1 and hold_cnt==MAX_HOLD: forced rotation. Pick from (o+1) mod 4.
    - If another requester is pending, hand over to it.
    - If only o is requesting, re-grant o.
    - In both cases hold_cnt<=1, q loads the new owner's data, valid<=1.
  - req[o]=0 and other req pending: hand over in the same edge (no idle bubble). Pick from (o+1) mod 4, load q, valid<=1, hold_cnt<=1.
  - req==0: go IDLE, grant<=0, valid<=0, owner and q hold.
- Latency:
  - One edge from req rising (in IDLE) to grant/valid/q.
  - req deassertion releases the grant at the next edge.
- Data sampling: d[owner] is sampled every owned cycle, so q tracks a streaming requester one cycle late.
- Simultaneous requests: resolved only by the ptr rotation; no fixed priority except immediately after reset.
- grant is never multi-hot. grant!=0 iff state==BUSY. valid==(grant!=0).
- hold_cnt saturates at MAX_HOLD and never wraps. MAX_HOLD=1 gives strict per-cycle rotation among active requesters.
- Reset mid-operation: all outputs return to reset values immediately, independent of clk. The first grant after release obeys ptr=0.
- q_bar is combinational from q and must never differ from ~q.

Test Plan:
1. Reset then idle: hold reset_n=0 10ns, release, req=0 for 3 cycles.
   - Required: grant=0000, owner=0, q=00, q_bar=FF, valid=0 throughout.
2. Single requester: req=0100, d2=A5 for 2 cycles, then req=0.
   - Required: grant=0100, owner=2, q=A5, q_bar=5A, valid=1 for exactly 2 cycles.
   - Then grant=0000, valid=0, q stays A5.
3. Simultaneous requests after reset: req=1111 held, d0..d3=10,20,30,40, MAX_HOLD=4.
   - Required: owner 0 for 4 cycles, then 1, 2, 3, 0, each for 4 cycles.
   - q follows 10,20,30,40, with no valid gap at handovers.
4. Early release handover: owner 1 active, req drops to 1001 with hold_cnt=2.
   - Required: next edge grant=1000 (index 3 found from ptr=2), q=d3, hold_cnt=1.
5. Lone hog: only req[0] held for 10 cycles.
   - Required: grant stays 0001 and valid stays 1 continuously (self re-grant at MAX_HOLD).
   - q tracks d0 one cycle late.
6. Async reset mid-burst: assert reset_n=0 between edges while grant=0010.
   - Required: grant=0000, q=00, valid=0 before the next clk edge.
   - After release with req=1111: first grant=0001.
